alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multicycle control/operand sequencer on the driving side of the team's combinational ALU.
- Accepts one register-register instruction at a time over a valid/ready handshake and reads both operands from the register file.
- Presents ri/rj/func to the ALU, captures the result and the compare flag, and writes the result back.
- Sits between the instruction source and the shared datapath (register file + ALU).

Parameters:
- N, 16, data width of operands, ALU result and register-file data.
- RA, 3, register-file address width (2**RA registers).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr_op  in  3  opcode (package encoding).
- instr_i  in  RA  destination / first source register.
- instr_j  in  RA  second source register.
- rf_raddr_i  out  RA  register-file read address, port i.
- rf_raddr_j  out  RA  register-file read address, port j.
- rf_rdata_i  in  N  combinational read data, port i.
- rf_rdata_j  in  N  combinational read data, port j.
- alu_ri  out  N  registered operand i to ALU.
- alu_rj  out  N  registered operand j to ALU.
- alu_func  out  3  ALU function select.
- alu_out  in  N  ALU result.
- alu_ne  in  1  ALU compare output: 1 when ri != rj, 0 when equal.
- rf_we  out  1  write-back strobe, one cycle.
- rf_waddr  out  RA  write-back address (= latched instr_i).
- rf_wdata  out  N  write-back data (latched ALU result).
- eq_flag  out  1  sticky result of last CMP: 1 when operands were equal.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse when a reserved opcode retires.

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; instr_ready=1; rf_we=0; done=0; illegal=0; eq_flag=0; alu_ri/alu_rj/rf_wdata=0; alu_func=PASS (000); latched op/addresses=0.
- Reset mid-instruction aborts it: no rf_we, no done.
- FSM, one state per cycle:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch op/i/j and go to READ.
  - READ: drive rf_raddr_i/j from latched i/j; at the edge, load alu_ri<=rf_rdata_i and alu_rj<=rf_rdata_j; go to EXEC.
  - EXEC: alu_func driven from latched op; at the edge, rf_wdata<=alu_out; go to WB. For CMP, eq_flag<=~alu_ne at this edge.
  - WB: rf_we=1 for MOV/ADD/SUB/AND/OR/NOT, 0 for CMP/NOP/reserved; done=1; illegal=1 only for reserved opcodes; go to IDLE.
- Latency: accept edge to done/rf_we = 3 cycles. Throughput: one instruction per 4 cycles.
- alu_func equals the package encoding in EXEC and is held at PASS in every other state.
- Arithmetic width: N-bit, wrap-around; no carry out.
- rf_raddr outputs hold the latched addresses outside READ.
- rf_waddr always equals the latched instr_i.
- instr_valid while busy is ignored: it is not latched, and the source must hold it until instr_ready.
- eq_flag changes only on CMP in EXEC or on reset.

Optional Feature:
- Macro: ALU_OP_SEQUENCER_PERF_EN.
- When defined: adds output retired_cnt (16 bits). It resets to 0 and increments on every done pulse, wrapping 0xFFFF->0. Reserved opcodes are counted too.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - ALU func constants: PASS=000, ADD=001, SUB=010, AND=011, OR=100, NOT=101 (~rj), PASS2=110.
  - Opcode constants: MOV=000, ADD=001, SUB=010, AND=011, OR=100, NOT=101, CMP=110, NOP=111.
  - FSM state encoding: IDLE, READ, EXEC, WB.
  - An opcode->func mapping function: CMP maps to SUB; NOP and reserved map to PASS.
- One sub-module is natural: alu_op_decode, a combinational opcode -> {func, writes_rf, is_cmp, is_illegal}.
- With the current 3-bit opcode there are no reserved values; the illegal path is kept for opcode width growth, and the decode module is sized by a package constant.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, mid-instruction (in EXEC) -> all outputs at reset values; no rf_we; instr_ready=1 next cycle.
- ADD: R1=0x0005, R2=0x0003, op=ADD i=1 j=2 -> alu_func=001 in EXEC; rf_we, waddr=1, wdata=0x0008 and done all exactly 3 cycles after accept.
- SUB wrap: R3=0x0000, R4=0x0001 -> wdata=0xFFFF to R3.
- NOT: R5=0x00F0 -> wdata=0xFF0F.
- CMP: R1=R2=0x1234 -> eq_flag=1, rf_we=0, done=1. Then R1=0x1234, R2=0x1235 -> eq_flag=0.
- Handshake: instr_valid held high continuously with 3 back-to-back instructions -> accepts spaced exactly 4 cycles apart, instr_ready low in READ/EXEC/WB, no instruction dropped or duplicated. With ALU_OP_SEQUENCER_PERF_EN, retired_cnt=3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand sequencer: ALU function codes, opcodes,
// FSM states, the decoded-instruction record and the opcode-to-function mapping.
package alu_pkg;

  localparam int OP_W   = 3;
  localparam int FUNC_W = 3;

  typedef enum logic [FUNC_W-1:0] {
    FN_PASS  = 3'b000,
    FN_ADD   = 3'b001,
    FN_SUB   = 3'b010,
    FN_AND   = 3'b011,
    FN_OR    = 3'b100,
    FN_NOT   = 3'b101,
    FN_PASS2 = 3'b110
  } func_e;

  typedef enum logic [OP_W-1:0] {
    OP_MOV = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_NOT = 3'b101,
    OP_CMP = 3'b110,
    OP_NOP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB
  } state_e;

  typedef struct packed {
    func_e func;
    logic  writes_rf;
    logic  is_cmp;
    logic  is_illegal;
  } dec_t;

  // CMP reuses the subtractor; NOP and any future reserved opcode leave the ALU passive.
  function automatic func_e op_to_func(input logic [OP_W-1:0] op);
    case (op)
      OP_MOV:  return FN_PASS;
      OP_ADD:  return FN_ADD;
      OP_SUB:  return FN_SUB;
      OP_AND:  return FN_AND;
      OP_OR:   return FN_OR;
      OP_NOT:  return FN_NOT;
      OP_CMP:  return FN_SUB;
      default: return FN_PASS;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake between an instruction source (master) and the
// ALU operand sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int RA = 3
);
  import alu_pkg::*;

  logic            instr_valid;
  logic            instr_ready;
  logic [OP_W-1:0] instr_op;
  logic [RA-1:0]   instr_i;
  logic [RA-1:0]   instr_j;

  modport master (
    output instr_valid,
    output instr_op,
    output instr_i,
    output instr_j,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_op,
    input  instr_i,
    input  instr_j,
    output instr_ready
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: ALU function, write-back enable, compare and
// reserved-opcode flags. Width follows alu_pkg::OP_W so reserved codes decode as illegal.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output dec_t            dec
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a latch behind.
    dec            = '0;
    dec.func       = op_to_func(op);
    case (op)
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: dec.writes_rf  = 1'b1;
      OP_CMP:                                        dec.is_cmp     = 1'b1;
      OP_NOP:                                        ;
      default:                                       dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-state operand sequencer driving the shared register file and ALU.
// Optional retired-instruction counter enabled by ALU_OP_SEQUENCER_PERF_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N  = 16,
  parameter int RA = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave instr,
  output logic [RA-1:0]     rf_raddr_i,
  output logic [RA-1:0]     rf_raddr_j,
  input  logic [N-1:0]      rf_rdata_i,
  input  logic [N-1:0]      rf_rdata_j,
  output logic [N-1:0]      alu_ri,
  output logic [N-1:0]      alu_rj,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [N-1:0]      alu_out,
  input  logic              alu_ne,
  output logic              rf_we,
  output logic [RA-1:0]     rf_waddr,
  output logic [N-1:0]      rf_wdata,
  output logic              eq_flag,
  output logic              done,
  output logic              illegal
`ifdef ALU_OP_SEQUENCER_PERF_EN
  ,
  output logic [15:0]       retired_cnt
`endif
);

  state_e          state;
  logic            ready_q;
  logic [OP_W-1:0] op_q;
  logic [RA-1:0]   i_q;
  logic [RA-1:0]   j_q;
  dec_t            dec;

  alu_op_decode u_decode (
    .op  (op_q),
    .dec (dec)
  );

  // Read and write addresses simply follow the latched instruction fields.
  assign instr.instr_ready = ready_q;
  assign rf_raddr_i        = i_q;
  assign rf_raddr_j        = j_q;
  assign rf_waddr          = i_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: every register here is plain control/datapath state with a defined reset value; there is no storage array to leave unreset.
      state    <= ST_IDLE;
      ready_q  <= 1'b1;
      op_q     <= '0;
      i_q      <= '0;
      j_q      <= '0;
      alu_ri   <= '0;
      alu_rj   <= '0;
      alu_func <= FN_PASS;
      rf_we    <= 1'b0;
      rf_wdata <= '0;
      eq_flag  <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rf_we   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr.instr_valid && ready_q) begin
            op_q    <= instr.instr_op;
            i_q     <= instr.instr_i;
            j_q     <= instr.instr_j;
            ready_q <= 1'b0;
            state   <= ST_READ;
          end
        end
        ST_READ: begin
          alu_ri   <= rf_rdata_i;
          alu_rj   <= rf_rdata_j;
          alu_func <= dec.func;
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          rf_wdata <= alu_out;
          if (dec.is_cmp) eq_flag <= ~alu_ne;
          alu_func <= FN_PASS;
          rf_we    <= dec.writes_rf;
          done     <= 1'b1;
          illegal  <= dec.is_illegal;
          state    <= ST_WB;
        end
        ST_WB: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_OP_SEQUENCER_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n)    retired_cnt <= '0;
    else if (done) retired_cnt <= retired_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: behavioural register file and ALU,
// per-instruction expectations queued at accept and checked at retire.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int N  = 16;
  localparam int RA = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.RA(RA)) instr_if ();

  logic [RA-1:0] rf_raddr_i, rf_raddr_j, rf_waddr;
  logic [N-1:0]  rf_rdata_i, rf_rdata_j, alu_ri, alu_rj, alu_out, rf_wdata;
  logic [2:0]    alu_func;
  logic          alu_ne, rf_we, eq_flag, done, illegal;
`ifdef ALU_OP_SEQUENCER_PERF_EN
  logic [15:0]   retired_cnt;
`endif

  alu_op_sequencer #(.N(N), .RA(RA)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr_if),
    .rf_raddr_i (rf_raddr_i),
    .rf_raddr_j (rf_raddr_j),
    .rf_rdata_i (rf_rdata_i),
    .rf_rdata_j (rf_rdata_j),
    .alu_ri     (alu_ri),
    .alu_rj     (alu_rj),
    .alu_func   (alu_func),
    .alu_out    (alu_out),
    .alu_ne     (alu_ne),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .eq_flag    (eq_flag),
    .done       (done),
    .illegal    (illegal)
`ifdef ALU_OP_SEQUENCER_PERF_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  // Environment: register file with a preload port, and the combinational ALU.
  logic [N-1:0]  rf [0:(1<<RA)-1];
  logic          pl_we;
  logic [RA-1:0] pl_a;
  logic [N-1:0]  pl_d;

  always @(posedge clk) begin
    if (pl_we)      rf[pl_a]     <= pl_d;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  assign rf_rdata_i = rf[rf_raddr_i];
  assign rf_rdata_j = rf[rf_raddr_j];

  always_comb begin
    alu_out = alu_ri;
    case (alu_func)
      3'b001:  alu_out = alu_ri + alu_rj;
      3'b010:  alu_out = alu_ri - alu_rj;
      3'b011:  alu_out = alu_ri & alu_rj;
      3'b100:  alu_out = alu_ri | alu_rj;
      3'b101:  alu_out = ~alu_rj;
      3'b110:  alu_out = alu_rj;
      default: alu_out = alu_ri;
    endcase
    alu_ne = (alu_ri != alu_rj);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [RA-1:0] i;
    logic [2:0]    func;
    logic          we;
    logic [N-1:0]  wdata;
    logic          eq;
    logic          ill;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   accs[$];
  logic model_eq = 1'b0;
  int   exp_cnt  = 0;

  function automatic logic [2:0] ref_func(input logic [2:0] op);
    case (op)
      3'b001:  return 3'b001;
      3'b010:  return 3'b010;
      3'b011:  return 3'b011;
      3'b100:  return 3'b100;
      3'b101:  return 3'b101;
      3'b110:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [N-1:0] ref_result(input logic [2:0] op, input logic [N-1:0] a,
                                              input logic [N-1:0] b);
    case (op)
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return ~b;
      default: return a;
    endcase
  endfunction

  // Retire monitor: timing of ready/func per pending instruction, then retire checks.
  int   mon_d;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sb.size() > 0) begin
        mon_d = cyc - sb[0].acc;
        if (mon_d == 2) check("exec_func", alu_func, sb[0].func);
        if (mon_d == 1 || mon_d == 3) check("func_pass", alu_func, 3'b000);
        if (mon_d >= 1 && mon_d <= 3) check("ready_busy", instr_if.instr_ready, 1'b0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", done, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          exp_cnt++;
          check("latency", cyc - mon_e.acc, 3);
          check("rf_we", rf_we, mon_e.we);
          check("rf_waddr", rf_waddr, mon_e.i);
          if (mon_e.we) check("rf_wdata", rf_wdata, mon_e.wdata);
          check("eq_flag", eq_flag, mon_e.eq);
          check("illegal", illegal, mon_e.ill);
        end
      end else if (rf_we) begin
        check("we_without_done", rf_we, 1'b0);
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after the accept.
  task automatic issue(input logic [2:0] op, input logic [RA-1:0] i, input logic [RA-1:0] j);
    exp_t e;
    int   k;
    instr_if.instr_op    = op;
    instr_if.instr_i     = i;
    instr_if.instr_j     = j;
    instr_if.instr_valid = 1'b1;
    k = 0;
    while (instr_if.instr_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (instr_if.instr_ready !== 1'b1) begin
      check("accept_timeout", instr_if.instr_ready, 1'b1);
      instr_if.instr_valid = 1'b0;
      return;
    end
    if (op == 3'b110) model_eq = (rf[i] == rf[j]);
    e.i     = i;
    e.func  = ref_func(op);
    e.we    = (op <= 3'b101);
    e.wdata = ref_result(op, rf[i], rf[j]);
    e.eq    = model_eq;
    e.ill   = 1'b0;
    e.acc   = cyc;
    sb.push_back(e);
    accs.push_back(cyc);
    @(negedge clk);
  endtask

  task automatic preload(input logic [RA-1:0] a, input logic [N-1:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic run_one(input logic [2:0] op, input logic [RA-1:0] i, input logic [RA-1:0] j);
    issue(op, i, j);
    instr_if.instr_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst_n                = 1'b0;
    pl_we                = 1'b0;
    pl_a                 = '0;
    pl_d                 = '0;
    instr_if.instr_valid = 1'b0;
    instr_if.instr_op    = '0;
    instr_if.instr_i     = '0;
    instr_if.instr_j     = '0;
    repeat (2) @(negedge clk);

    check("rst_ready", instr_if.instr_ready, 1'b1);
    check("rst_we", rf_we, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_eq", eq_flag, 1'b0);
    check("rst_ri", alu_ri, 16'h0000);
    check("rst_rj", alu_rj, 16'h0000);
    check("rst_wdata", rf_wdata, 16'h0000);
    check("rst_func", alu_func, 3'b000);
    check("rst_raddr_i", rf_raddr_i, 3'd0);
    check("rst_waddr", rf_waddr, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0003);
    preload(3'd3, 16'h0000);
    preload(3'd4, 16'h0001);
    preload(3'd5, 16'h00F0);
    run_one(3'b001, 3'd1, 3'd2);
    check("add_rf", rf[1], 16'h0008);
    run_one(3'b010, 3'd3, 3'd4);
    check("sub_wrap_rf", rf[3], 16'hFFFF);
    run_one(3'b101, 3'd5, 3'd5);
    check("not_rf", rf[5], 16'hFF0F);
    run_one(3'b011, 3'd1, 3'd2);
    run_one(3'b100, 3'd2, 3'd5);

    preload(3'd1, 16'h1234);
    preload(3'd2, 16'h1234);
    run_one(3'b110, 3'd1, 3'd2);
    check("cmp_eq_rf_kept", rf[1], 16'h1234);
    preload(3'd2, 16'h1235);
    run_one(3'b110, 3'd1, 3'd2);
    run_one(3'b111, 3'd1, 3'd1);

    preload(3'd1, 16'h0001);
    preload(3'd2, 16'h0002);
    preload(3'd3, 16'h0003);
    issue(3'b001, 3'd1, 3'd2);
    issue(3'b010, 3'd3, 3'd1);
    issue(3'b100, 3'd2, 3'd3);
    instr_if.instr_valid = 1'b0;
    wait_idle();
    check("b2b_space_1", accs[accs.size()-2] - accs[accs.size()-3], 4);
    check("b2b_space_2", accs[accs.size()-1] - accs[accs.size()-2], 4);
    check("b2b_r1", rf[1], 16'h0003);
    check("b2b_r3", rf[3], 16'h0000);
    check("b2b_r2", rf[2], 16'h0002);
`ifdef ALU_OP_SEQUENCER_PERF_EN
    check("retired_cnt", retired_cnt, exp_cnt[15:0]);
`endif

    // Abort an ADD in EXEC after a CMP has set eq_flag.
    preload(3'd1, 16'h0777);
    preload(3'd2, 16'h0777);
    run_one(3'b110, 3'd1, 3'd2);
    preload(3'd7, 16'h0AAA);
    preload(3'd1, 16'h0001);
    issue(3'b001, 3'd7, 3'd1);
    instr_if.instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    model_eq = 1'b0;
    exp_cnt  = 0;
    repeat (2) @(negedge clk);
    check("abort_we", rf_we, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_eq", eq_flag, 1'b0);
    check("abort_wdata", rf_wdata, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", instr_if.instr_ready, 1'b1);
    check("abort_rf7", rf[7], 16'h0AAA);
`ifdef ALU_OP_SEQUENCER_PERF_EN
    check("retired_cnt_rst", retired_cnt, 16'h0000);
`endif

    run_one(3'b001, 3'd7, 3'd1);
    check("recover_rf7", rf[7], 16'h0AAB);
`ifdef ALU_OP_SEQUENCER_PERF_EN
    check("retired_cnt_after", retired_cnt, exp_cnt[15:0]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
